// File: rtl/airi5c_fetch_ctrl_pkg.sv
// Shared control constants for the AIRI5C fetch front end.
// Holds the architectural widths, the PC mux select encodings used by both
// airi5c_fetch_ctrl and airi5c_pc_mux, and the RV32 NOP that the IF
// instruction register holds after reset.
package airi5c_fetch_ctrl_pkg;

  localparam int XPR_LEN          = 32;
  localparam int INST_WIDTH       = 32;
  localparam int PC_SRC_SEL_WIDTH = 4;

  // PC mux select encodings
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JAL_TARGET     = 4'd0;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JALR_TARGET    = 4'd1;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_BRANCH_TARGET  = 4'd2;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_REPLAY         = 4'd3;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_HANDLER        = 4'd4;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_EPC            = 4'd5;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_MISSED_PREDICT = 4'd6;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_PLUS_FOUR      = 4'd7;
  localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_DPC            = 4'd8;

  localparam logic [INST_WIDTH-1:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/airi5c_fetch_ctrl.sv
// airi5c_fetch_ctrl -- instruction fetch sequencer with one outstanding request.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o/addr_o     fetch request and address (address = fetch_pc)
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i fetch response
//   if_valid_o/if_ready_i instruction handshake towards IF
//   inst_if_o, pc_if_o    presented instruction and its PC
//   fetch_pc_o            current fetch PC, feeds the PC mux
//   pc_src_sel_o          PC mux select (combinational)
//   pc_pif_i              PC mux result
//   exception_i .. mispredict_i  EX-stage redirect events
//   halt_req_i, dret_i    debug halt request / resume
//   halted_o              fetch halted
//
// Handshakes: the memory side accepts a request in any cycle where
// imem_req_o and imem_gnt_i are both high; a response is one cycle with
// imem_rvalid_i high. On the IF side an instruction transfers in a cycle
// where if_valid_o and if_ready_i are both high; while if_valid_o is high
// without if_ready_i, inst_if_o and pc_if_o hold stable.
//
// The FSM state is kept in the enum signal 'state' so checkers can bind to it.
module airi5c_fetch_ctrl
  import airi5c_fetch_ctrl_pkg::*;
#(
  parameter logic [XPR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        imem_req_o,
  output logic [XPR_LEN-1:0]          imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [INST_WIDTH-1:0]       imem_rdata_i,
  output logic                        if_valid_o,
  input  logic                        if_ready_i,
  output logic [INST_WIDTH-1:0]       inst_if_o,
  output logic [XPR_LEN-1:0]          pc_if_o,
  output logic [XPR_LEN-1:0]          fetch_pc_o,
  output logic [PC_SRC_SEL_WIDTH-1:0] pc_src_sel_o,
  input  logic [XPR_LEN-1:0]          pc_pif_i,
  input  logic                        exception_i,
  input  logic                        mret_i,
  input  logic                        jal_i,
  input  logic                        jalr_i,
  input  logic                        branch_taken_i,
  input  logic                        mispredict_i,
  input  logic                        halt_req_i,
  input  logic                        dret_i,
  output logic                        halted_o
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_HALT
  } state_e;

  state_e                  state, state_next;
  logic [XPR_LEN-1:0]      fetch_pc, fetch_pc_next;
  logic [XPR_LEN-1:0]      pc_if, pc_if_next;
  logic [INST_WIDTH-1:0]   inst_if, inst_if_next;
  logic                    halt_pend, halt_pend_next;
  logic                    redirect;
  logic                    halt_take;
  state_e                  leave_state;

  assign redirect = exception_i | mret_i | jalr_i | jal_i | branch_taken_i | mispredict_i;
  // A halt request raised this very cycle counts as pending already.
  assign halt_take   = halt_pend | halt_req_i;
  assign leave_state = halt_take ? S_HALT : S_FETCH;

  // PC mux select: fixed priority over the event inputs.
  always_comb begin
    pc_src_sel_o = PC_PLUS_FOUR;
    if (state == S_HALT && dret_i)          pc_src_sel_o = PC_DPC;
    else if (exception_i)                   pc_src_sel_o = PC_HANDLER;
    else if (mret_i)                        pc_src_sel_o = PC_EPC;
    else if (jalr_i)                        pc_src_sel_o = PC_JALR_TARGET;
    else if (jal_i)                         pc_src_sel_o = PC_JAL_TARGET;
    else if (branch_taken_i)                pc_src_sel_o = PC_BRANCH_TARGET;
    else if (mispredict_i)                  pc_src_sel_o = PC_MISSED_PREDICT;
    else if (state == S_FETCH || state == S_HALT) pc_src_sel_o = PC_REPLAY;
  end

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    pc_if_next     = pc_if;
    inst_if_next   = inst_if;
    halt_pend_next = halt_pend | halt_req_i;
    unique case (state)
      S_BOOT: state_next = S_FETCH;
      S_FETCH: begin
        if (redirect) fetch_pc_next = pc_pif_i;
        // A redirect racing a grant leaves a response in flight to drain.
        if (imem_gnt_i)     state_next = redirect ? S_DRAIN : S_WAIT;
        else if (halt_take) state_next = S_HALT;
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_next = pc_pif_i;
          state_next    = imem_rvalid_i ? S_FETCH : S_DRAIN;
        end else if (imem_rvalid_i) begin
          inst_if_next  = imem_rdata_i;
          pc_if_next    = fetch_pc;
          fetch_pc_next = pc_pif_i;
          state_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect wins over a simultaneous IF handshake: instruction is dropped.
        if (redirect) begin
          fetch_pc_next = pc_pif_i;
          state_next    = leave_state;
        end else if (if_ready_i) begin
          state_next    = leave_state;
        end
      end
      S_DRAIN: begin
        if (redirect)      fetch_pc_next = pc_pif_i;
        if (imem_rvalid_i) state_next    = leave_state;
      end
      S_HALT: begin
        if (dret_i) begin
          fetch_pc_next  = pc_pif_i;
          halt_pend_next = 1'b0;
          state_next     = S_FETCH;
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_BOOT;
      fetch_pc  <= RESET_PC;
      pc_if     <= '0;
      inst_if   <= RV_NOP;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      pc_if     <= pc_if_next;
      inst_if   <= inst_if_next;
      halt_pend <= halt_pend_next;
    end
  end

  assign imem_req_o  = (state == S_FETCH);
  assign imem_addr_o = fetch_pc;
  assign fetch_pc_o  = fetch_pc;
  assign if_valid_o  = (state == S_HOLD);
  assign inst_if_o   = inst_if;
  assign pc_if_o     = pc_if;
  assign halted_o    = (state == S_HALT);

endmodule

// File: tb/tb_airi5c_fetch_ctrl.sv
// Testbench for airi5c_fetch_ctrl: directed scenarios followed by a
// randomized run against a stream-level model (delivered instructions are
// sequential from the last redirect target, data = mem_fn(pc)).
module tb_airi5c_fetch_ctrl;
  import airi5c_fetch_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_i;
  logic                        imem_req_o;
  logic [XPR_LEN-1:0]          imem_addr_o;
  logic                        imem_gnt_i;
  logic                        imem_rvalid_i;
  logic [INST_WIDTH-1:0]       imem_rdata_i;
  logic                        if_valid_o;
  logic                        if_ready_i;
  logic [INST_WIDTH-1:0]       inst_if_o;
  logic [XPR_LEN-1:0]          pc_if_o;
  logic [XPR_LEN-1:0]          fetch_pc_o;
  logic [PC_SRC_SEL_WIDTH-1:0] pc_src_sel_o;
  logic [XPR_LEN-1:0]          pc_pif_i;
  logic exception_i, mret_i, jal_i, jalr_i, branch_taken_i, mispredict_i;
  logic halt_req_i, dret_i;
  logic halted_o;

  logic [31:0] target_val;
  logic [31:0] dpc_val;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // PC mux model closing the loop.
  assign pc_pif_i = (pc_src_sel_o == PC_PLUS_FOUR) ? fetch_pc_o + 32'd4 :
                    (pc_src_sel_o == PC_REPLAY)    ? fetch_pc_o :
                    (pc_src_sel_o == PC_DPC)       ? dpc_val : target_val;

  airi5c_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .inst_if_o(inst_if_o), .pc_if_o(pc_if_o), .fetch_pc_o(fetch_pc_o),
    .pc_src_sel_o(pc_src_sel_o), .pc_pif_i(pc_pif_i),
    .exception_i(exception_i), .mret_i(mret_i), .jal_i(jal_i), .jalr_i(jalr_i),
    .branch_taken_i(branch_taken_i), .mispredict_i(mispredict_i),
    .halt_req_i(halt_req_i), .dret_i(dret_i), .halted_o(halted_o)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    exception_i = 0; mret_i = 0; jal_i = 0; jalr_i = 0;
    branch_taken_i = 0; mispredict_i = 0; dret_i = 0; halt_req_i = 0;
  endtask

  task automatic clear_inputs();
    clear_events();
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0; if_ready_i = 0;
    target_val = 32'h0; dpc_val = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, imem_req_o, 0);
    chk({tag, "_if_valid"}, if_valid_o, 0);
    chk({tag, "_halted"}, halted_o, 0);
    chk({tag, "_inst"}, inst_if_o, 32'h0000_0013);
    chk({tag, "_pc_if"}, pc_if_o, 32'h0);
    chk({tag, "_fetch_pc"}, fetch_pc_o, 32'h8000_0000);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pdly;
    int          n_deliv;
    bit          rv, g, redir;

    // ---------------- reset ----------------
    clear_inputs();
    rst_i = 1;
    cyc(); cyc();
    check_reset_values("reset");
    rst_i = 0;

    // ---------------- first fetch ----------------
    imem_gnt_i = 1;
    cyc();                                   // BOOT -> FETCH
    chk("boot_req", imem_req_o, 1);
    chk("boot_addr", imem_addr_o, 32'h8000_0000);
    cyc();                                   // granted -> WAIT
    imem_gnt_i = 0;
    chk("wait_no_req", imem_req_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'hCAFE_0001;
    cyc();                                   // -> HOLD
    imem_rvalid_i = 0;
    chk("first_valid", if_valid_o, 1);
    chk("first_pc", pc_if_o, 32'h8000_0000);
    chk("first_inst", inst_if_o, 32'hCAFE_0001);
    chk("first_next_pc", fetch_pc_o, 32'h8000_0004);
    if_ready_i = 1;
    cyc();                                   // -> FETCH
    if_ready_i = 0;
    chk("second_req", imem_req_o, 1);
    chk("second_addr", imem_addr_o, 32'h8000_0004);
    chk("second_no_valid", if_valid_o, 0);

    // ---------------- select priority ----------------
    #1 chk("sel_replay", pc_src_sel_o, PC_REPLAY);
    jal_i = 1; branch_taken_i = 1;
    #1 chk("sel_jal_over_branch", pc_src_sel_o, PC_JAL_TARGET);
    jal_i = 0; branch_taken_i = 0; mret_i = 1; jalr_i = 1;
    #1 chk("sel_epc_over_jalr", pc_src_sel_o, PC_EPC);
    clear_events();
    exception_i = 1; jal_i = 1; target_val = 32'h8000_0200;
    #1 chk("sel_handler_over_jal", pc_src_sel_o, PC_HANDLER);
    cyc();                                   // redirect in FETCH, no grant
    clear_events();
    chk("redir_fetch_req", imem_req_o, 1);
    chk("redir_fetch_addr", imem_addr_o, 32'h8000_0200);

    // ---------------- branch in WAIT -> DRAIN ----------------
    imem_gnt_i = 1;
    cyc();                                   // -> WAIT
    imem_gnt_i = 0;
    branch_taken_i = 1; target_val = 32'h8000_0100;
    #1 chk("sel_branch", pc_src_sel_o, PC_BRANCH_TARGET);
    cyc();                                   // -> DRAIN
    branch_taken_i = 0;
    chk("drain_req", imem_req_o, 0);
    chk("drain_valid", if_valid_o, 0);
    cyc();
    chk("drain2_valid", if_valid_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
    cyc();                                   // stale response dropped -> FETCH
    imem_rvalid_i = 0;
    chk("drain_exit_valid", if_valid_o, 0);
    chk("drain_exit_req", imem_req_o, 1);
    chk("drain_exit_addr", imem_addr_o, 32'h8000_0100);

    // ---------------- HOLD stall ----------------
    imem_gnt_i = 1;
    cyc();
    imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'h1234_5678;
    cyc();                                   // -> HOLD
    imem_rvalid_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_inst", inst_if_o, 32'h1234_5678);
      chk("hold_pc", pc_if_o, 32'h8000_0100);
      chk("hold_no_req", imem_req_o, 0);
      chk("hold_valid", if_valid_o, 1);
      cyc();
    end
    if_ready_i = 1;
    cyc();
    if_ready_i = 0;
    chk("hold_exit_addr", imem_addr_o, 32'h8000_0104);

    // ---------------- redirect in HOLD beats if_ready ----------------
    imem_gnt_i = 1;
    cyc();
    imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'h5555_AAAA;
    cyc();                                   // -> HOLD
    imem_rvalid_i = 0;
    if_ready_i = 1; mispredict_i = 1; target_val = 32'h8000_0500;
    cyc();
    if_ready_i = 0; clear_events();
    chk("hold_redir_valid", if_valid_o, 0);
    chk("hold_redir_addr", imem_addr_o, 32'h8000_0500);

    // ---------------- halt requested during WAIT ----------------
    imem_gnt_i = 1;
    cyc();                                   // -> WAIT
    imem_gnt_i = 0; halt_req_i = 1;
    cyc();
    halt_req_i = 0;
    chk("halt_wait_not_halted", halted_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'h0BAD_F00D;
    cyc();                                   // -> HOLD
    imem_rvalid_i = 0;
    chk("halt_hold_valid", if_valid_o, 1);
    chk("halt_hold_not_halted", halted_o, 0);
    if_ready_i = 1;
    cyc();                                   // consumed -> HALT
    if_ready_i = 0;
    chk("halted", halted_o, 1);
    chk("halted_no_req", imem_req_o, 0);
    jal_i = 1; target_val = 32'h8000_0300;
    cyc();
    clear_events();
    chk("halt_ignore_jal", halted_o, 1);
    chk("halt_ignore_jal_pc", fetch_pc_o, 32'h8000_0504);
    dret_i = 1; dpc_val = 32'h8000_0040;
    #1 chk("sel_dpc", pc_src_sel_o, PC_DPC);
    cyc();
    dret_i = 0;
    chk("dret_halted", halted_o, 0);
    chk("dret_req", imem_req_o, 1);
    chk("dret_addr", imem_addr_o, 32'h8000_0040);

    // ---------------- halt taken in FETCH without grant ----------------
    halt_req_i = 1;
    cyc();
    halt_req_i = 0;
    chk("halt_fetch", halted_o, 1);
    dret_i = 1; dpc_val = 32'h8000_0080;
    cyc();
    dret_i = 0;
    chk("halt_fetch_resume", imem_addr_o, 32'h8000_0080);

    // ---------------- reset mid-transaction ----------------
    imem_gnt_i = 1;
    cyc();                                   // -> WAIT
    imem_gnt_i = 0; rst_i = 1;
    cyc();
    check_reset_values("midreset");
    rst_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hBADB_ADBA;
    cyc();                                   // BOOT -> FETCH, stale rvalid
    chk("stale_req", imem_req_o, 1);
    chk("stale_addr", imem_addr_o, 32'h8000_0000);
    cyc();
    imem_rvalid_i = 0;
    chk("stale_no_valid", if_valid_o, 0);
    chk("stale_addr2", imem_addr_o, 32'h8000_0000);

    // ---------------- randomized run ----------------
    clear_inputs();
    rst_i = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_i = 0;
    exp_pc  = 32'h8000_0000;
    pdly    = 0;
    n_deliv = 0;
    exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      clear_events();
      // memory responder: one response per grant after 1..3 cycles
      rv = 0;
      if (exp_q.size() != 0) begin
        if (pdly == 0) rv = 1;
        else pdly--;
      end
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? exp_q.pop_front() : $urandom;
      if (exp_q.size() != 0) chk("one_outstanding", imem_req_o, 0);
      g = imem_req_o && ($urandom_range(0, 2) != 0);
      imem_gnt_i = g;
      if (g) begin
        exp_q.push_back(mem_fn(imem_addr_o));
        pdly = $urandom_range(0, 2);
      end
      if_ready_i = $urandom_range(0, 1);
      redir = (c >= 3) && ($urandom_range(0, 9) == 0);
      if (redir) begin
        target_val = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
        case ($urandom_range(0, 5))
          0: exception_i = 1;
          1: mret_i = 1;
          2: jalr_i = 1;
          3: jal_i = 1;
          4: branch_taken_i = 1;
          default: mispredict_i = 1;
        endcase
      end
      // stream model for the coming edge
      if (redir) begin
        exp_pc = target_val;
      end else if (if_valid_o && if_ready_i) begin
        chk("rand_pc", pc_if_o, exp_pc);
        chk("rand_inst", inst_if_o, mem_fn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (c % 100 == 0) chk("rand_not_halted", halted_o, 0);
    end
    chk("rand_progress", (n_deliv > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/airi5c_fetch_ctrl.md
AIRI5C_FETCH_CTRL -- requirements
Module: airi5c_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XPR_LEN  fetch address (= fetch_pc)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  INST_WIDTH  response data
- if_valid_o  out  1  instruction presented to IF
- if_ready_i  in  1  IF consumes instruction
- inst_if_o  out  INST_WIDTH  presented instruction
- pc_if_o  out  XPR_LEN  PC of presented instruction
- fetch_pc_o  out  XPR_LEN  current fetch PC; drives the PC mux pc_if_i input
- pc_src_sel_o  out  PC_SRC_SEL_WIDTH  PC mux select
- pc_pif_i  in  XPR_LEN  PC mux result
- exception_i, mret_i, jal_i, jalr_i, branch_taken_i, mispredict_i  in  1 each  EX-stage redirect events
- halt_req_i, dret_i  in  1 each  debug halt / resume
- halted_o  out  1  core fetch halted

Function
REQ-003 SHALL implement states BOOT, FETCH, WAIT, HOLD, DRAIN, HALT; maximum one outstanding request.
REQ-004 SHALL drive pc_src_sel_o by fixed priority: HALT with dret_i -> PC_DPC; exception_i -> PC_HANDLER; mret_i -> PC_EPC; jalr_i -> PC_JALR_TARGET; jal_i -> PC_JAL_TARGET; branch_taken_i -> PC_BRANCH_TARGET; mispredict_i -> PC_MISSED_PREDICT; no event in FETCH/HALT -> PC_REPLAY; otherwise PC_PLUS_FOUR.
REQ-005 "Redirect" SHALL mean any of exception_i, mret_i, jalr_i, jal_i, branch_taken_i, mispredict_i asserted; on redirect fetch_pc SHALL load pc_pif_i at the clock edge.
REQ-006 BOOT: one cycle after reset, no request, then FETCH with fetch_pc = RESET_PC.
REQ-007 FETCH: imem_req_o=1; imem_gnt_i -> WAIT; no grant -> stay; redirect without grant -> stay, new address next cycle.
REQ-008 WAIT: imem_req_o=0; on imem_rvalid_i latch rdata to inst_if_o, fetch_pc to pc_if_o, set if_valid_o next cycle, fetch_pc <= pc_pif_i (PC_PLUS_FOUR), -> HOLD.
REQ-009 HOLD: if_valid_o=1; data and pc_if_o stable until if_ready_i; on if_valid_o&if_ready_i -> FETCH same edge; throughput thereby 1 instruction / 3 cycles minimum.
REQ-010 Redirect in WAIT without rvalid -> DRAIN; next rvalid SHALL be discarded, then FETCH.
REQ-011 Redirect in WAIT coincident with rvalid -> response discarded, -> FETCH, if_valid_o stays 0.
REQ-012 Redirect in HOLD -> buffered instruction dropped (if_valid_o 0 next cycle), -> FETCH, even if if_ready_i is high that cycle.
REQ-013 Redirect coincident with grant in FETCH -> DRAIN.
REQ-014 halt_req_i SHALL be latched into a pending flag; taken when in FETCH without grant or on leaving DRAIN/HOLD -> HALT; halted_o=1 in HALT; no requests in HALT.
REQ-015 HALT: dret_i -> fetch_pc <= pc_pif_i, clear pending halt, -> FETCH; redirects other than dret_i ignored.
REQ-016 imem_rvalid_i outside WAIT/DRAIN SHALL be ignored.
REQ-017 pc_src_sel_o SHALL be combinational from state and event inputs; all other outputs registered or decoded from state.

Reset
REQ-018 rst_i high at a clock edge: state BOOT, fetch_pc=RESET_PC, pc_if_o=0, inst_if_o=RV32 NOP (32'h0000_0013), if_valid_o=0, imem_req_o=0, halted_o=0, halt-pending cleared; overrides all events including mid-transaction.

Structure
REQ-019 PC_* select encodings, PC_SRC_SEL_WIDTH, XPR_LEN, INST_WIDTH SHALL come from the shared airi5c_ctrl_constants / arch-options headers; state encoding local.
REQ-020 No sub-module; instantiated as sibling of airi5c_pc_mux, pc_src_sel_o/fetch_pc_o/pc_pif_i forming the loop.

Verification
REQ-021 Reset release, gnt=1 immediately, rvalid 1 cycle later -> imem_addr_o=32'h8000_0000, then if_valid_o with pc_if_o=32'h8000_0000, next request 32'h8000_0004.
REQ-022 Branch redirect in WAIT (pc_pif_i=32'h8000_0100), rvalid two cycles later -> data dropped, next request 32'h8000_0100, if_valid_o never set for old fetch.
REQ-023 exception_i and jal_i same cycle -> pc_src_sel_o=PC_HANDLER.
REQ-024 HOLD with if_ready_i=0 for 5 cycles -> inst_if_o/pc_if_o stable, no imem_req_o.
REQ-025 halt_req_i in WAIT -> halted_o after response consumed; dret_i with pc_pif_i=32'h8000_0040 -> next request 32'h8000_0040.
REQ-026 rst_i asserted in WAIT, stale rvalid after reset -> ignored, first request 32'h8000_0000.
